// File: rtl/conv_encoder_sys.sv
// -----------------------------------------------------------------------------
// conv_encoder_sys
// Rate-1/2 feedforward convolutional encoder with per-frame selectable
// constraint length K (3..6). One data bit per accepted input beat becomes one
// 2-bit coded symbol. Every frame is terminated with K-1 zero tail bits, so the
// trellis returns to state 0 before the next frame starts.
//
// Ports
//   clk                       rising-edge clock
//   rst_n                     asynchronous, active-low reset
//   choose_constraint_length  requested K; sampled when a frame's first bit fires
//   in_valid / in_ready       input handshake (in_ready is combinational)
//   in_bit                    data bit
//   in_last                   marks the final data bit of a frame
//   out_valid / out_ready     output handshake
//   encoded_bits              {g0, g1} coded symbol
//   out_last                  marks the final tail symbol of a frame
// -----------------------------------------------------------------------------
module conv_encoder_sys #(
  parameter int MAX_K = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] choose_constraint_length,
  input  logic       in_valid,
  input  logic       in_bit,
  input  logic       in_last,
  output logic       in_ready,
  output logic       out_valid,
  output logic [1:0] encoded_bits,
  output logic       out_last,
  input  logic       out_ready
);

  localparam int SW = MAX_K - 1;  // shift register length

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    TAIL = 2'd2
  } state_t;

  // Unsupported requests fall back to the smallest code.
  function automatic logic [2:0] clamp_k(input logic [2:0] k);
    if ((int'(k) >= 3) && (int'(k) <= 6) && (int'(k) <= MAX_K)) begin
      return k;
    end
    return 3'd3;
  endfunction

  // Generator taps left-aligned in the {u, s1..s(MAX_K-1)} window, so the MSB
  // always multiplies the current input and unused low taps are zero.
  function automatic logic [MAX_K-1:0] tap_mask(input logic [2:0] k, input logic sel_g1);
    logic [5:0]       g;
    logic [MAX_K-1:0] m;
    case (k)
      3'd4:    g = sel_g1 ? 6'o17 : 6'o15;
      3'd5:    g = sel_g1 ? 6'o35 : 6'o23;
      3'd6:    g = sel_g1 ? 6'o75 : 6'o53;
      default: g = sel_g1 ? 6'o05 : 6'o07;
    endcase
    m = MAX_K'(g);
    m = m << (MAX_K - int'(k));
    return m;
  endfunction

  state_t         state_q, state_d;
  logic [1:SW]    sreg_q, sreg_d;      // sreg_q[1] is the most recent prior bit
  logic [2:0]     k_q, k_d;
  logic [2:0]     k_eff;
  logic [2:0]     tail_cnt_q, tail_cnt_d;
  logic           out_free;
  logic           in_fire;
  logic           gen;                 // a symbol is produced this cycle
  logic           u;                   // encoder input for this symbol
  logic           tail_last;
  logic [MAX_K-1:0] win;
  logic [MAX_K-1:0] mask_g0, mask_g1;
  logic [1:SW]    keep;
  logic [1:0]     sym;

  // ---------------------------------------------------------------------------
  // Next-state and datapath logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path can
    // leave it unassigned and infer a latch.
    state_d    = state_q;
    tail_cnt_d = tail_cnt_q;
    k_eff      = k_q;
    k_d        = k_q;
    gen        = 1'b0;
    u          = 1'b0;
    tail_last  = 1'b0;

    out_free = !out_valid || out_ready;
    in_ready = (state_q != TAIL) && out_free;
    in_fire  = in_valid && in_ready;

    // A new frame uses the requested K immediately for its first symbol.
    if (state_q == IDLE) begin
      k_eff = clamp_k(choose_constraint_length);
    end

    unique case (state_q)
      IDLE, DATA: begin
        if (in_fire) begin
          gen = 1'b1;
          u   = in_bit;
          if (state_q == IDLE) begin
            k_d = k_eff;
          end
          if (in_last) begin
            state_d    = TAIL;
            tail_cnt_d = 3'(k_eff - 3'd1);
          end else begin
            state_d = DATA;
          end
        end
      end
      TAIL: begin
        // Tail zeros advance whenever the output register can take a symbol.
        if (out_free) begin
          gen        = 1'b1;
          u          = 1'b0;
          tail_cnt_d = 3'(tail_cnt_q - 3'd1);
          if (tail_cnt_q == 3'd1) begin
            tail_last = 1'b1;
            state_d   = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    mask_g0 = tap_mask(k_eff, 1'b0);
    mask_g1 = tap_mask(k_eff, 1'b1);
    win     = {u, sreg_q};
    sym     = {^(win & mask_g0), ^(win & mask_g1)};

    // Stages beyond K-1 are held at zero so a later, longer frame never sees
    // leftovers from a shorter one.
    for (int i = 1; i <= SW; i++) begin
      keep[i] = (i <= int'(k_eff) - 1);
    end

    sreg_d = sreg_q;
    if (gen) begin
      sreg_d = {u, sreg_q[1:SW-1]} & keep;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sreg_q     <= '0;
      k_q        <= 3'd3;
      tail_cnt_q <= 3'd0;
    end else begin
      state_q    <= state_d;
      sreg_q     <= sreg_d;
      k_q        <= k_d;
      tail_cnt_q <= tail_cnt_d;
    end
  end

  // Output register: loads on generation, holds under backpressure, and drops
  // valid/last once the symbol is consumed with nothing new behind it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the data register is reset too, so encoded_bits reads a defined
      // 2'b00 after reset rather than whatever the flops powered up with.
      out_valid    <= 1'b0;
      encoded_bits <= 2'b00;
      out_last     <= 1'b0;
    end else if (gen) begin
      out_valid    <= 1'b1;
      encoded_bits <= sym;
      out_last     <= tail_last;
    end else if (out_ready) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_conv_encoder_sys.sv
// -----------------------------------------------------------------------------
// tb_conv_encoder_sys
// Directed scoreboard bench for conv_encoder_sys. Stimulus pushes hand-computed
// expected symbols ({out_last, encoded_bits}) into a queue; a monitor pops and
// compares on every output handshake and also checks stall behaviour.
// -----------------------------------------------------------------------------
module tb_conv_encoder_sys;

  logic       clk;
  logic       rst_n;
  logic [2:0] choose_constraint_length;
  logic       in_valid;
  logic       in_bit;
  logic       in_last;
  logic       in_ready;
  logic       out_valid;
  logic [1:0] encoded_bits;
  logic       out_last;
  logic       out_ready;

  int checks   = 0;
  int failures = 0;

  logic [2:0] exp_q[$];
  bit         bp_mode = 1'b0;
  logic [3:0] bp_pat  = 4'b1001;
  int         cyc     = 0;

  conv_encoder_sys #(.MAX_K(6)) dut (
    .clk                      (clk),
    .rst_n                    (rst_n),
    .choose_constraint_length (choose_constraint_length),
    .in_valid                 (in_valid),
    .in_bit                   (in_bit),
    .in_last                  (in_last),
    .in_ready                 (in_ready),
    .out_valid                (out_valid),
    .encoded_bits             (encoded_bits),
    .out_last                 (out_last),
    .out_ready                (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [1:0] sym, input logic last);
    exp_q.push_back({last, sym});
  endtask

  // Present one bit and hold it until the DUT accepts it; returns just after
  // the accepting edge with in_valid dropped.
  task automatic drive_bit(input logic b, input logic l);
    bit ok = 1'b0;
    int n  = 0;
    in_valid = 1'b1;
    in_bit   = b;
    in_last  = l;
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    check("accept_timeout", 32'(ok), 32'd1);
    in_valid = 1'b0;
    in_bit   = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  // Downstream ready: always 1, or the repeating 1,0,0,1 pattern.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      out_ready = bp_mode ? bp_pat[cyc % 4] : 1'b1;
    end
  end

  // Monitor: compares on handshakes, checks stability and in_ready on stalls.
  initial begin
    logic [2:0] e;
    logic [1:0] held;
    bit         stalled = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stalled = 1'b0;
      end else begin
        if (stalled) begin
          check("stall_hold", {30'd0, out_valid, 1'b0} | {30'd0, 1'b0, 1'b0}, 32'd2);
          check("stall_bits", 32'(encoded_bits), 32'(held));
          stalled = 1'b0;
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_symbol: got %0b%02b expected none", out_last, encoded_bits);
          end else begin
            e = exp_q.pop_front();
            check("symbol", 32'({out_last, encoded_bits}), 32'(e));
          end
        end else if (out_valid && !out_ready) begin
          check("stall_in_ready", 32'(in_ready), 32'd0);
          held    = encoded_bits;
          stalled = 1'b1;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n                    = 1'b0;
    choose_constraint_length = 3'd3;
    in_valid                 = 1'b0;
    in_bit                   = 1'b0;
    in_last                  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_bits", 32'(encoded_bits), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // 1: K=3, bits 1,0,1,1
    choose_constraint_length = 3'd3;
    push(2'b11, 0); push(2'b10, 0); push(2'b00, 0); push(2'b01, 0);
    push(2'b01, 0); push(2'b11, 1);
    drive_bit(1, 0); drive_bit(0, 0); drive_bit(1, 0); drive_bit(1, 1);
    wait_drain();

    // 2: K=4 impulse, in_ready low for the 3 tail cycles
    @(posedge clk); #1;
    choose_constraint_length = 3'd4;
    push(2'b11, 0); push(2'b11, 0); push(2'b01, 0); push(2'b11, 1);
    drive_bit(1, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("tail_in_ready_low", 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    check("tail_in_ready_back", 32'(in_ready), 32'd1);
    wait_drain();

    // 3: test 1 under backpressure
    @(posedge clk); #1;
    bp_mode = 1'b1;
    choose_constraint_length = 3'd3;
    push(2'b11, 0); push(2'b10, 0); push(2'b00, 0); push(2'b01, 0);
    push(2'b01, 0); push(2'b11, 1);
    drive_bit(1, 0); drive_bit(0, 0); drive_bit(1, 0); drive_bit(1, 1);
    wait_drain();
    bp_mode = 1'b0;
    repeat (2) @(negedge clk);

    // 4: K=7 clamps to 3; mid-frame change to 6 ignored
    @(posedge clk); #1;
    choose_constraint_length = 3'd7;
    push(2'b11, 0); push(2'b01, 0); push(2'b01, 0); push(2'b11, 1);
    drive_bit(1, 0);
    choose_constraint_length = 3'd6;
    drive_bit(1, 1);
    wait_drain();

    // 5: reset mid-frame (K=5), then a K=3 single-bit frame
    @(posedge clk); #1;
    choose_constraint_length = 3'd5;
    push(2'b11, 0); push(2'b01, 0);
    drive_bit(1, 0); drive_bit(0, 0); drive_bit(1, 0);
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_out_last", 32'(out_last), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    choose_constraint_length = 3'd3;
    push(2'b11, 0); push(2'b10, 0); push(2'b11, 1);
    drive_bit(1, 1);
    wait_drain();

    // 6: back-to-back single-bit frames
    @(posedge clk); #1;
    choose_constraint_length = 3'd3;
    push(2'b11, 0); push(2'b10, 0); push(2'b11, 1);
    push(2'b11, 0); push(2'b10, 0); push(2'b11, 1);
    drive_bit(1, 1);
    drive_bit(1, 1);
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
